// File: rtl/button_conditioner.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module : button_conditioner                                                 |
// | Brief  : 2-flop sync, debounce and edge/step arbitration for izq/der/fire.  |
// |          Optional auto-repeat of held direction steps under AUTOREPEAT_EN.  |
// | Rev    : 1.0                                                                |
// +-----------------------------------------------------------------------------+
module button_conditioner #(
`ifdef AUTOREPEAT_EN
  parameter int REPEAT_DELAY    = 15000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int REP_W           = 24,
`endif
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic izq,
  input  logic der,
  input  logic fire,
  output logic izq_level,
  output logic der_level,
  output logic fire_level,
  output logic izq_step,
  output logic der_step,
  output logic fire_pulse
);

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HELD    = 2'd1,
    ST_BLOCKED = 2'd2
  } dir_state_e;

  // Bit order everywhere: 0 = izq, 1 = der, 2 = fire.
  logic [2:0] w_raw;
  logic [2:0] r_s1;
  logic [2:0] r_s2;
  logic [2:0] w_deb;
  logic [2:0] r_level;
  logic [2:0] w_rise;
  logic [2:0] w_fall;
  logic [1:0] w_step;
  logic       r_fire_pulse;

  assign w_raw = {fire, der, izq};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= 3'b000;
      r_s2 <= 3'b000;
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_debounce
      logic [CNT_W-1:0] r_cnt;
      logic             r_deb;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_cnt <= '0;
          r_deb <= 1'b0;
        end else if (r_s2[gi] == r_deb) begin
          r_cnt <= '0;
        end else if (r_cnt == C_CNT_LAST) begin
          r_cnt <= '0;
          r_deb <= ~r_deb;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end

      assign w_deb[gi] = r_deb;
    end
  endgenerate

  // r_level lags the internal debounced value by one cycle, so rise/fall
  // seen here line up with the cycle in which the level output changes.
  assign w_rise = w_deb & ~r_level;
  assign w_fall = ~w_deb & r_level;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_level      <= 3'b000;
      r_fire_pulse <= 1'b0;
    end else begin
      r_level      <= w_deb;
      r_fire_pulse <= w_rise[2];
    end
  end

  generate
    for (genvar gd = 0; gd < 2; gd++) begin : g_dir
      localparam int C_OTH = 1 - gd;

      dir_state_e r_state;
      dir_state_e w_state_nxt;
      logic       w_step_nxt;
      logic       r_step;
      logic       w_rep_fire;

`ifdef AUTOREPEAT_EN
      localparam logic [REP_W-1:0] C_REP_DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
      localparam logic [REP_W-1:0] C_REP_PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

      logic [REP_W-1:0] r_rep;
      logic             r_rep_first;

      assign w_rep_fire = (r_state == ST_HELD) &&
                          (r_rep == (r_rep_first ? C_REP_DELAY_LAST : C_REP_PERIOD_LAST));

      // Restarts on entry to HELD (the press pulse) and after every repeat step.
      always_ff @(posedge clk) begin
        if (reset || (w_state_nxt != ST_HELD) || (r_state != ST_HELD)) begin
          r_rep       <= '0;
          r_rep_first <= 1'b1;
        end else if (w_step_nxt) begin
          r_rep       <= '0;
          r_rep_first <= 1'b0;
        end else begin
          r_rep <= r_rep + REP_W'(1);
        end
      end
`else
      assign w_rep_fire = 1'b0;
`endif

      always_ff @(posedge clk) begin
        if (reset) begin
          r_state <= ST_IDLE;
          r_step  <= 1'b0;
        end else begin
          r_state <= w_state_nxt;
          r_step  <= w_step_nxt;
        end
      end

      always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = 1'b0;
        case (r_state)
          ST_IDLE: begin
            if (w_rise[gd]) begin
              if (w_deb[C_OTH]) begin
                w_state_nxt = ST_BLOCKED;
              end else begin
                w_state_nxt = ST_HELD;
                w_step_nxt  = 1'b1;
              end
            end
          end
          ST_HELD: begin
            if (w_fall[gd]) begin
              w_state_nxt = ST_IDLE;
            end else if (w_rise[C_OTH]) begin
              w_state_nxt = ST_BLOCKED;
            end else begin
              w_step_nxt = w_rep_fire;
            end
          end
          ST_BLOCKED: begin
            if (w_fall[gd]) begin
              w_state_nxt = ST_IDLE;
            end
          end
          default: begin
            w_state_nxt = ST_IDLE;
          end
        endcase
      end

      assign w_step[gd] = r_step;
    end
  endgenerate

  assign izq_level  = r_level[0];
  assign der_level  = r_level[1];
  assign fire_level = r_level[2];
  assign izq_step   = w_step[0];
  assign der_step   = w_step[1];
  assign fire_pulse = r_fire_pulse;

endmodule
`default_nettype wire
